branch_ctrl: RTL and testbench

ID-stage branch controller for the pipelined MIPS core. Evaluates the condition of BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ from forwarded register values, stalls the front end while a needed operand is still in flight, and issues a registered one-cycle redirect to the IF-stage PC mux. It also counts resolved and taken branches and flags stalls that exceed the pipeline's hazard bound.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond.sv | 33 +++
 rtl/branch_ctrl.sv | 96 +++++++++
 tb/tb_branch_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the ID-stage branch controller: opcode encoding,
// FSM state encoding and the operand-need helper.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BGTZ = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Only the two-register compares depend on rt; everything else tests rs alone.
  function automatic logic needs_rt(input logic [2:0] op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Purely combinational branch-condition evaluator. Reserved opcodes are
// never taken.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        taken
);

  logic rs_nonneg;
  logic rs_nonzero;

  assign rs_nonneg  = ~rs[31];
  assign rs_nonzero = |rs;

  // Select the condition for the current opcode.
  always_comb begin
    // NOTE: taken gets a default before the case so no path leaves it unassigned (no latch).
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = (rs == rt);
      BR_BNE:  taken = (rs != rt);
      BR_BGTZ: taken = rs_nonneg & rs_nonzero;
      BR_BLEZ: taken = rs[31] | ~rs_nonzero;
      BR_BLTZ: taken = rs[31];
      BR_BGEZ: taken = rs_nonneg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: stalls while operands are in flight, issues a
// registered one-cycle redirect, keeps saturating branch statistics and a
// sticky wait-limit error flag.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic [31:0]      target,
  output logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             err
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ok;
  logic              taken;
  logic              resolve;

  branch_cond u_cond (
    .op    (br_op),
    .rs    (rs_val),
    .rt    (rt_val),
    .taken (taken)
  );

  // Operands are usable when rs is final and rt is either final or unused.
  assign ok      = rs_ready & (rt_ready | ~needs_rt(br_op));
  assign resolve = br_valid & ok;
  assign stall   = ~reset & br_valid & ~ok;

  // FSM, wait counter, redirect registers, statistics and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      // NOTE: all state here uses <= so every register samples pre-edge values.
      redirect <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (br_valid && !ok) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!br_valid || ok) begin
            // Either a flush or the branch resolves now; both return to IDLE.
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase

      if (resolve) begin
        redirect <= taken;
        if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
        if (taken) begin
          redirect_pc <= target;
          if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl. Each step drives inputs, checks stall
// combinationally, pushes the expected registered outputs to a scoreboard
// and pops/compares them one cycle later.
module tb_branch_ctrl;

  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             br_valid;
  logic [2:0]       br_op;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             rs_ready;
  logic             rt_ready;
  logic [31:0]      target;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic             err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        redirect;
    logic [31:0] pc;
    logic        chk_pc;
    logic [15:0] br;
    logic [15:0] tk;
    logic        err;
  } exp_t;

  exp_t q[$];

  // Reference model state
  bit          m_wait_st;
  int          m_wait;
  int          m_br;
  int          m_tk;
  bit          m_err;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  branch_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .br_valid    (br_valid),
    .br_op       (br_op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .rs_ready    (rs_ready),
    .rt_ready    (rt_ready),
    .target      (target),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .br_cnt      (br_cnt),
    .taken_cnt   (taken_cnt),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic v, input logic [2:0] op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic rsr,
                      input logic rtr, input logic [31:0] tgt, input bit chk);
    bit   ok;
    bit   tk;
    exp_t e;
    exp_t got;
    reset = rst; br_valid = v; br_op = op; rs_val = rs; rt_val = rt;
    rs_ready = rsr; rt_ready = rtr; target = tgt;
    #1;
    ok = rsr && (rtr || !(op == 3'd0 || op == 3'd1));
    case (op)
      3'd0:    tk = (rs == rt);
      3'd1:    tk = (rs != rt);
      3'd2:    tk = ($signed(rs) > 0);
      3'd3:    tk = ($signed(rs) <= 0);
      3'd4:    tk = ($signed(rs) < 0);
      3'd5:    tk = ($signed(rs) >= 0);
      default: tk = 1'b0;
    endcase
    if (chk) check({tag, ".stall"}, 32'(stall), 32'(!rst && v && !ok));

    e.redirect = 1'b0;
    e.chk_pc   = 1'b0;
    if (rst) begin
      m_wait_st = 0; m_wait = 0; m_br = 0; m_tk = 0; m_err = 0; m_pc = '0;
      e.chk_pc  = 1'b1;
    end else begin
      if (v && ok) begin
        if (m_br < 16'hFFFF) m_br++;
        e.redirect = tk;
        if (tk) begin
          if (m_tk < 16'hFFFF) m_tk++;
          m_pc     = tgt;
          e.chk_pc = 1'b1;
        end
      end
      if (v && !ok) begin
        if (!m_wait_st) begin
          m_wait_st = 1; m_wait = 1;
        end else if (m_wait == MAX_WAIT) begin
          m_err = 1;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait_st = 0; m_wait = 0;
      end
    end
    e.pc  = m_pc;
    e.br  = 16'(m_br);
    e.tk  = 16'(m_tk);
    e.err = m_err;
    q.push_back(e);

    @(posedge clk);
    #1;
    got = q.pop_front();
    if (chk) begin
      check({tag, ".redirect"}, 32'(redirect), 32'(got.redirect));
      if (got.chk_pc) check({tag, ".redirect_pc"}, redirect_pc, got.pc);
      check({tag, ".br_cnt"}, 32'(br_cnt), 32'(got.br));
      check({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(got.tk));
      check({tag, ".err"}, 32'(err), 32'(got.err));
    end
  endtask

  initial begin
    reset = 1'b1; br_valid = 1'b0; br_op = '0; rs_val = '0; rt_val = '0;
    rs_ready = 1'b0; rt_ready = 1'b0; target = '0;
    @(posedge clk); #1;

    // Reset state
    step("reset", 1, 0, 3'd0, 0, 0, 0, 0, 0, 1);
    step("idle", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // BEQ ready, taken
    step("beq", 0, 1, 3'd0, 32'h5, 32'h5, 1, 1, 32'h3010, 1);
    step("beq_after", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // BGTZ sign boundaries
    step("bgtz_pos", 0, 1, 3'd2, 32'h1, 0, 1, 0, 32'h4000, 1);
    step("bgtz_zero", 0, 1, 3'd2, 32'h0, 0, 1, 0, 32'h4100, 1);
    step("bgtz_neg", 0, 1, 3'd2, 32'h8000_0000, 0, 1, 0, 32'h4200, 1);
    step("gap", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // Remaining ops, back-to-back
    step("blez_neg", 0, 1, 3'd3, 32'hFFFF_FFFF, 0, 1, 0, 32'h5000, 1);
    step("bltz_pos", 0, 1, 3'd4, 32'h7FFF_FFFF, 0, 1, 0, 32'h5100, 1);
    step("bgez_zero", 0, 1, 3'd5, 32'h0, 0, 1, 0, 32'h5200, 1);
    step("beq_ne", 0, 1, 3'd0, 32'h1, 32'h2, 1, 1, 32'h5300, 1);
    step("rsvd", 0, 1, 3'd7, 32'h1, 32'h1, 1, 1, 32'h5400, 1);

    // BNE waits two cycles on rt
    step("bne_w1", 0, 1, 3'd1, 32'h1, 32'h2, 1, 0, 32'h6000, 1);
    step("bne_w2", 0, 1, 3'd1, 32'h1, 32'h2, 1, 0, 32'h6000, 1);
    step("bne_go", 0, 1, 3'd1, 32'h1, 32'h2, 1, 1, 32'h6000, 1);
    step("bne_after", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // rs not ready for MAX_WAIT+1 cycles raises err, then a normal resolve
    for (int i = 0; i < MAX_WAIT + 1; i++)
      step("wait_lim", 0, 1, 3'd5, 32'h10, 0, 0, 0, 32'h7000, 1);
    step("wait_extra", 0, 1, 3'd5, 32'h10, 0, 0, 0, 32'h7000, 1);
    step("wait_go", 0, 1, 3'd5, 32'h10, 0, 1, 0, 32'h7000, 1);
    step("wait_after", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // Flush out of WAIT
    step("flush_w", 0, 1, 3'd0, 32'h3, 32'h3, 0, 1, 32'h8000, 1);
    step("flush", 0, 0, 3'd0, 32'h3, 32'h3, 1, 1, 32'h8000, 1);
    step("flush_after", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // Reset during WAIT, with a resolvable branch presented during reset
    step("rst_w", 0, 1, 3'd0, 32'h9, 32'h9, 1, 0, 32'h9000, 1);
    step("rst_win", 1, 1, 3'd0, 32'h9, 32'h9, 1, 1, 32'h9000, 1);
    step("rst_after", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);

    // Fill br_cnt to all-ones with reserved ops, then one more
    for (int i = 0; i < 65535; i++)
      step("fill", 0, 1, 3'd6, 0, 0, 1, 1, 0, 0);
    step("sat_full", 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);
    step("sat_more", 0, 1, 3'd4, 32'h8000_0000, 0, 1, 0, 32'hA000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
